// File: rtl/iot_sensor_pkg.sv
// Shared types and constants for the sensor bus scheduler.
package iot_sensor_pkg;
   localparam int SCH_NUM_REQ = 4;

   localparam logic [1:0] SCH_ERR_OK      = 2'b00;
   localparam logic [1:0] SCH_ERR_NACK    = 2'b01;
   localparam logic [1:0] SCH_ERR_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      SCH_IDLE,
      SCH_GRANT,
      SCH_START,
      SCH_WAIT,
      SCH_RESP
   } sched_state_e;
endpackage

// File: rtl/rr_arbiter_picker.sv
// Combinational round-robin pick: search from i_ptr upward with wrap.
module rr_arbiter_picker #(
   parameter  int NUM_REQ = 4,
   localparam int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PW-1:0]      i_ptr,
   output logic               o_any,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [PW-1:0]      o_idx
);
   logic [PW:0]   w_sum;
   logic [PW-1:0] w_j;

   always_comb begin
      o_any    = 1'b0;
      o_onehot = '0;
      o_idx    = '0;
      w_sum    = '0;
      w_j      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(NUM_REQ))
            w_sum = w_sum - (PW+1)'(NUM_REQ);
         w_j = w_sum[PW-1:0];
         if (!o_any && i_req[w_j]) begin
            o_any         = 1'b1;
            o_onehot[w_j] = 1'b1;
            o_idx         = w_j;
         end
      end
   end
endmodule

// File: rtl/i2c_sensor_bus_scheduler.sv
// Shares one I2C byte engine between several sensor requesters,
// round-robin, with 1/2-byte sequencing and per-byte timeout.
module i2c_sensor_bus_scheduler
   import iot_sensor_pkg::*;
#(
   parameter int NUM_REQ        = SCH_NUM_REQ,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*7-1:0] req_addr,
   input  logic [NUM_REQ-1:0]   req_rw_n,
   input  logic [NUM_REQ*8-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]   req_len2,
   output logic                 m_start,
   output logic [6:0]           m_addr,
   output logic                 m_rw_n,
   output logic [7:0]           m_wdata,
   input  logic [7:0]           m_rdata,
   input  logic                 m_done,
   input  logic                 m_ack_error,
   output logic [NUM_REQ-1:0]   resp_valid,
   output logic [1:0]           resp_err,
   output logic [15:0]          resp_rdata,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   sched_state_e  r_state;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_idx;
   logic          r_len2;
   logic          r_byte;
   logic [7:0]    r_hi;
   logic [TW-1:0] r_tcnt;

   logic               w_any;
   logic [NUM_REQ-1:0] w_onehot;
   logic [PW-1:0]      w_idx;
   logic               w_more;
   logic [15:0]        w_fin;
   logic [PW-1:0]      w_ptr_nxt;

   rr_arbiter_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_any    (w_any),
      .o_onehot (w_onehot),
      .o_idx    (w_idx)
   );

   assign w_more = r_len2 && !r_byte;
   assign w_ptr_nxt = (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + PW'(1);

   // Final byte lands low for 2-byte reads; writes report zero.
   always_comb begin
      w_fin = 16'h0000;
      if (m_rw_n)
         w_fin = r_len2 ? {r_hi, m_rdata} : {8'h00, m_rdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= SCH_IDLE;
         r_ptr      <= '0;
         r_idx      <= '0;
         r_len2     <= 1'b0;
         r_byte     <= 1'b0;
         r_hi       <= '0;
         r_tcnt     <= '0;
         m_start    <= 1'b0;
         m_addr     <= '0;
         m_rw_n     <= 1'b0;
         m_wdata    <= '0;
         resp_valid <= '0;
         resp_err   <= SCH_ERR_OK;
         resp_rdata <= '0;
         grant      <= '0;
         busy       <= 1'b0;
      end else begin
         m_start    <= 1'b0;
         resp_valid <= '0;
         case (r_state)
            SCH_IDLE: begin
               if (enable && w_any) begin
                  r_idx   <= w_idx;
                  r_len2  <= req_len2[w_idx];
                  r_byte  <= 1'b0;
                  r_hi    <= '0;
                  m_addr  <= req_addr[int'(w_idx)*7 +: 7];
                  m_rw_n  <= req_rw_n[w_idx];
                  m_wdata <= req_wdata[int'(w_idx)*8 +: 8];
                  grant   <= w_onehot;
                  busy    <= 1'b1;
                  r_state <= SCH_GRANT;
               end
            end
            SCH_GRANT: begin
               m_start <= 1'b1;
               r_state <= SCH_START;
            end
            SCH_START: begin
               r_tcnt  <= '0;
               r_state <= SCH_WAIT;
            end
            SCH_WAIT: begin
               if (m_ack_error) begin
                  resp_valid <= grant;
                  resp_err   <= SCH_ERR_NACK;
                  resp_rdata <= {r_hi, 8'h00};
                  r_state    <= SCH_RESP;
               end else if (m_done) begin
                  if (w_more) begin
                     r_byte  <= 1'b1;
                     r_hi    <= m_rw_n ? m_rdata : 8'h00;
                     m_start <= 1'b1;
                     r_state <= SCH_START;
                  end else begin
                     resp_valid <= grant;
                     resp_err   <= SCH_ERR_OK;
                     resp_rdata <= w_fin;
                     r_state    <= SCH_RESP;
                  end
               end else if (r_tcnt == TLAST) begin
                  resp_valid <= grant;
                  resp_err   <= SCH_ERR_TIMEOUT;
                  resp_rdata <= {r_hi, 8'h00};
                  r_state    <= SCH_RESP;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            SCH_RESP: begin
               resp_err   <= SCH_ERR_OK;
               resp_rdata <= '0;
               grant      <= '0;
               m_addr     <= '0;
               m_rw_n     <= 1'b0;
               m_wdata    <= '0;
               busy       <= 1'b0;
               r_ptr      <= w_ptr_nxt;
               r_state    <= SCH_IDLE;
            end
            default: r_state <= SCH_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_sensor_bus_scheduler.sv
// Randomized scoreboard bench for i2c_sensor_bus_scheduler.
module tb_i2c_sensor_bus_scheduler;
   localparam int N  = 4;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           enable;
   logic [N-1:0]   req;
   logic [N*7-1:0] req_addr;
   logic [N-1:0]   req_rw_n;
   logic [N*8-1:0] req_wdata;
   logic [N-1:0]   req_len2;
   logic           m_start;
   logic [6:0]     m_addr;
   logic           m_rw_n;
   logic [7:0]     m_wdata;
   logic [7:0]     m_rdata;
   logic           m_done;
   logic           m_ack_error;
   logic [N-1:0]   resp_valid;
   logic [1:0]     resp_err;
   logic [15:0]    resp_rdata;
   logic [N-1:0]   grant;
   logic           busy;

   always #5 clk = ~clk;

   i2c_sensor_bus_scheduler #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .req         (req),
      .req_addr    (req_addr),
      .req_rw_n    (req_rw_n),
      .req_wdata   (req_wdata),
      .req_len2    (req_len2),
      .m_start     (m_start),
      .m_addr      (m_addr),
      .m_rw_n      (m_rw_n),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_done      (m_done),
      .m_ack_error (m_ack_error),
      .resp_valid  (resp_valid),
      .resp_err    (resp_err),
      .resp_rdata  (resp_rdata),
      .grant       (grant),
      .busy        (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input bit ok, input string nm,
                      input longint act, input longint exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          idx;
      logic [1:0]  err;
      logic [15:0] data;
      longint      cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] got[$];
   logic [7:0] dir_bytes[$];

   longint     cyc = 0;
   int         m_ptr = 0;
   int         cur_idx = 0;
   bit         cur_rw = 0;
   bit         cur_len2 = 0;
   logic [6:0] cur_addr = '0;
   logic [7:0] cur_wd = '0;
   bit         exp_start = 0;
   int         nbytes = 0;
   bit         mute = 0;
   bit         drv_on = 0;
   bit         drop[N];
   int         resp_cnt[N];

   logic [N-1:0]   req_q;
   logic [N*7-1:0] addr_q;
   logic [N-1:0]   rw_q;
   logic [N*8-1:0] wd_q;
   logic [N-1:0]   len2_q;
   logic           en_q;
   logic           rst_q;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      req_q  <= req;
      addr_q <= req_addr;
      rw_q   <= req_rw_n;
      wd_q   <= req_wdata;
      len2_q <= req_len2;
      en_q   <= enable;
      rst_q  <= rst_n;
   end

   // Reference arbitration: first requester at or after the pointer.
   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (p + k) % N;
         if (r[j[1:0]]) return j;
      end
      return 0;
   endfunction

   // Bytes received so far, placed as the requester sees them.
   function automatic logic [15:0] exp_data();
      int d;
      d = 0;
      if (cur_rw)
         for (int k = 0; k < got.size(); k++)
            d = d + int'(got[k]) * ((cur_len2 && k == 0) ? 256 : 1);
      return 16'(d);
   endfunction

   // Monitor: grant prediction, idle outputs, response scoreboard.
   initial begin
      bit prev_busy, prev_start, after_resp;
      int w;
      exp_t e;
      prev_busy  = 0;
      prev_start = 0;
      after_resp = 0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && rst_q === 1'b1) begin
            if (after_resp)
               chk(busy == 0 && grant == 0, "busy_drop",
                   {busy, grant}, 0);
            after_resp = 0;
            if (!prev_busy) begin
               if (en_q && req_q != 0) begin
                  w = rr_pick(req_q, m_ptr);
                  chk(grant == N'(1 << w), "grant_rr", grant, 1 << w);
                  chk(busy == 1, "grant_busy", busy, 1);
                  cur_idx   = w;
                  cur_addr  = addr_q[w*7 +: 7];
                  cur_rw    = rw_q[w];
                  cur_wd    = wd_q[w*8 +: 8];
                  cur_len2  = len2_q[w];
                  chk(m_addr == cur_addr, "grant_addr", m_addr, cur_addr);
                  nbytes    = 0;
                  got.delete();
                  exp_start = 1;
               end else begin
                  chk(grant == 0 && busy == 0 && m_addr == 0 &&
                      m_wdata == 0 && m_rw_n == 0 && m_start == 0 &&
                      resp_valid == 0, "idle_outputs",
                      {grant, busy, m_addr, m_wdata, m_rw_n}, 0);
               end
            end
            if (prev_start)
               chk(m_start == 0, "start_width", m_start, 0);
            if (resp_valid != 0) begin
               if (sb.size() == 0) begin
                  chk(0, "unexpected_resp", resp_valid, 0);
               end else begin
                  e = sb.pop_front();
                  chk(resp_valid == N'(1 << e.idx), "resp_onehot",
                      resp_valid, 1 << e.idx);
                  chk(resp_err == e.err, "resp_err", resp_err, e.err);
                  chk(resp_rdata == e.data, "resp_rdata",
                      resp_rdata, e.data);
                  chk(cyc == e.cyc, "resp_cycle", cyc, e.cyc);
                  resp_cnt[e.idx]++;
                  drop[e.idx] = 1;
                  m_ptr = (e.idx + 1) % N;
                  after_resp = 1;
               end
            end
         end
         prev_busy  = (busy === 1'b1);
         prev_start = (m_start === 1'b1);
      end
   end

   // I2C master model: random byte outcomes, pushes expected responses.
   initial begin
      int oc, d;
      bit stray;
      logic [7:0] b;
      longint c;
      m_done      = 0;
      m_ack_error = 0;
      m_rdata     = '0;
      forever begin
         @(negedge clk);
         if (m_start !== 1'b1) continue;
         chk(exp_start == 1, "start_expected", 0, 1);
         exp_start = 0;
         chk(m_addr == cur_addr, "m_addr", m_addr, cur_addr);
         chk(m_rw_n == cur_rw, "m_rw_n", m_rw_n, cur_rw);
         chk(m_wdata == cur_wd, "m_wdata", m_wdata, cur_wd);
         c = cyc;
         if (mute) continue;
         oc = $urandom_range(0, 99);
         oc = (oc < 62) ? 0 : (oc < 77) ? 1 : (oc < 88) ? 2 : 3;
         d  = $urandom_range(0, 4);
         b  = 8'($urandom);
         if (dir_bytes.size() > 0) begin
            oc = 0;
            d  = 0;
            b  = dir_bytes.pop_front();
         end
         stray = (oc == 0) && ($urandom_range(0, 5) == 0);
         if (stray) begin
            m_done  = 1;
            m_rdata = 8'($urandom);
         end
         @(posedge clk);
         #1;
         m_done = 0;
         if (oc == 3) begin
            sb.push_back('{idx: cur_idx, err: 2'b10,
                           data: exp_data(), cyc: c + 1 + TO});
            continue;
         end
         repeat (d) begin
            @(posedge clk);
            #1;
         end
         m_rdata     = b;
         m_done      = (oc == 0 || oc == 2);
         m_ack_error = (oc == 1 || oc == 2);
         @(posedge clk);
         #1;
         m_done      = 0;
         m_ack_error = 0;
         if (oc == 0) begin
            nbytes++;
            got.push_back(b);
            if (nbytes == (cur_len2 ? 2 : 1))
               sb.push_back('{idx: cur_idx, err: 2'b00,
                              data: exp_data(), cyc: c + 2 + d});
            else
               exp_start = 1;
         end else begin
            sb.push_back('{idx: cur_idx, err: 2'b01,
                           data: exp_data(), cyc: c + 2 + d});
         end
      end
   end

   // Requester driver: drops served requests, raises new random ones.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         for (int i = 0; i < N; i++) begin
            if (drop[i]) begin
               req[i]  = 0;
               drop[i] = 0;
            end else if (drv_on && !req[i] &&
                         $urandom_range(0, 3) == 0) begin
               req_addr[i*7 +: 7]  = 7'($urandom);
               req_wdata[i*8 +: 8] = 8'($urandom);
               req_rw_n[i]         = 1'($urandom);
               req_len2[i]         = 1'($urandom);
               req[i]              = 1;
            end
            if (drv_on && grant[i] && $urandom_range(0, 3) == 0) begin
               req_addr[i*7 +: 7]  = 7'($urandom);
               req_wdata[i*8 +: 8] = 8'($urandom);
               req_rw_n[i]         = 1'($urandom);
               req_len2[i]         = 1'($urandom);
            end
         end
         if (drv_on) enable = ($urandom_range(0, 4) != 0);
      end
   end

   task automatic wait_resp(input int i, input int lim);
      int s;
      bit seen;
      s    = resp_cnt[i];
      seen = 0;
      for (int k = 0; k < lim && !seen; k++) begin
         @(negedge clk);
         seen = (resp_cnt[i] != s);
      end
      chk(seen, "resp_wait", i, 1);
   endtask

   task automatic wait_idle(input int lim);
      int q;
      q = 0;
      for (int k = 0; k < lim && q < 3; k++) begin
         @(negedge clk);
         q = (busy == 0 && sb.size() == 0) ? q + 1 : 0;
      end
      chk(q >= 3, "drain", q, 3);
   endtask

   initial begin
      bit seen;
      rst_n     = 0;
      enable    = 0;
      req       = '0;
      req_addr  = '0;
      req_rw_n  = '0;
      req_wdata = '0;
      req_len2  = '0;
      for (int i = 0; i < N; i++) begin
         drop[i]     = 0;
         resp_cnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(grant == 0 && busy == 0 && m_start == 0, "reset_ctl",
          {grant, busy, m_start}, 0);
      chk(resp_valid == 0 && resp_err == 0 && resp_rdata == 0,
          "reset_resp", {resp_valid, resp_err, resp_rdata}, 0);
      chk(m_addr == 0 && m_rw_n == 0 && m_wdata == 0, "reset_master",
          {m_addr, m_rw_n, m_wdata}, 0);
      #2 rst_n = 1;

      // 2-byte read from 0x48 returning 1A then 80
      dir_bytes.push_back(8'h1A);
      dir_bytes.push_back(8'h80);
      @(posedge clk);
      #4;
      req_addr[6:0] = 7'h48;
      req_rw_n[0]   = 1;
      req_len2[0]   = 1;
      req[0]        = 1;
      enable        = 1;
      wait_resp(0, 100);
      wait_idle(50);

      // Pending requests must wait for enable
      @(posedge clk);
      #4;
      enable        = 0;
      req_addr[13:7]  = 7'h40;
      req_addr[20:14] = 7'h77;
      req_wdata[15:8] = 8'hA5;
      req_rw_n[2:1]   = 2'b01;
      req_len2[2:1]   = 2'b10;
      req[2:1]        = 2'b11;
      repeat (12) @(posedge clk);
      #4;
      enable = 1;
      wait_resp(1, 100);
      wait_resp(2, 100);
      wait_idle(50);

      // Random traffic
      drv_on = 1;
      repeat (4000) @(posedge clk);
      #4;
      drv_on = 0;
      enable = 0;
      wait_idle(200);
      @(posedge clk);
      #4;
      req    = '0;
      enable = 1;
      wait_idle(20);

      // Reset while waiting on the master; pointer restarts at 0
      @(posedge clk);
      #4;
      mute = 1;
      req_addr[6:0]   = 7'h11;
      req_addr[20:14] = 7'h22;
      req_rw_n[0]     = 1;
      req_rw_n[2]     = 1;
      req_len2[0]     = 0;
      req_len2[2]     = 1;
      req[0]          = 1;
      req[2]          = 1;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         seen = (m_start == 1);
      end
      chk(seen, "start_wait", seen, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk(grant == 0 && busy == 0 && m_start == 0 && m_addr == 0 &&
          m_rw_n == 0 && m_wdata == 0, "async_reset_ctl",
          {grant, busy, m_addr}, 0);
      chk(resp_valid == 0 && resp_err == 0 && resp_rdata == 0,
          "async_reset_resp", {resp_valid, resp_err, resp_rdata}, 0);
      @(negedge clk);
      #2;
      m_ptr     = 0;
      exp_start = 0;
      mute      = 0;
      rst_n     = 1;
      wait_resp(0, 100);
      wait_resp(2, 100);
      wait_idle(50);
      chk(sb.size() == 0, "sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
